lcd_cmd_host: RTL and testbench
===============================

// Module: lcd_cmd_host
// PURPOSE
//  Initiator side of the LCD controller command interface: buffers commands from a testbench/CPU
//  push port and issues them over cmd/cmd_valid, honouring busy. On a WRITE (0) command it
//  captures the 64-pixel IRAM write-back stream into a local frame buffer and checksums it.
//  Sits between the command source and the LCD controller; the frame buffer is read back by the host.
// PARAMETERS
//  FIFO_DEPTH   16   command FIFO entries (power of two, >=2)
//  PIX_W        8    pixel width (IRAM_D)
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-high reset
//  push_valid   in   1      command push strobe
//  push_cmd     in   4      command code pushed
//  push_ready   out  1      FIFO not full; push accepted when push_valid&push_ready
//  busy         in   1      controller busy
//  cmd          out  4      command to controller
//  cmd_valid    out  1      one-cycle command strobe
//  IRAM_valid   in   1      controller pixel write strobe
//  IRAM_A       in   6      pixel write address
//  IRAM_D       in   PIX_W  pixel write data
//  done         in   1      controller frame write-back finished
//  rd_addr      in   6      frame buffer read address
//  rd_data      out  PIX_W  frame buffer data, registered, 1-cycle latency
//  frame_done   out  1      one-cycle pulse when a capture completes
//  checksum     out  14     sum of 64 captured pixels (max 16320)
//  pix_cnt      out  7      pixels captured in current/last frame (0..64)
//  drop_cnt     out  8      illegal codes (12..15) discarded, saturating at 255
// BEHAVIOUR
//  Reset: cmd=0, cmd_valid=0, push_ready=1, rd_data=0, frame_done=0, checksum=0, pix_cnt=0,
//   drop_cnt=0, FIFO empty, frame buffer contents undefined, state IDLE.
//  Push filter: codes 12..15 never enter FIFO; accepted pushes of them increment drop_cnt.
//   Push on full FIFO is ignored (push_ready=0); simultaneous push+pop on full is legal.
//  FSM: IDLE -> ISSUE when FIFO non-empty and busy==0.
//   ISSUE: drive cmd=head, cmd_valid=1 for exactly one cycle, pop FIFO. -> GUARD.
//   GUARD: one dead cycle (controller may raise busy late); cmd_valid=0. -> WAIT.
//   WAIT: if issued cmd==WRITE -> CAPTURE (clear checksum, pix_cnt); else when busy==0 -> IDLE.
//   CAPTURE: each cycle IRAM_valid=1 stores IRAM_D at IRAM_A, checksum+=IRAM_D, pix_cnt++.
//    Exit on done=1 or pix_cnt reaching 64 (whichever first): frame_done pulse, -> HALT if done
//    else -> IDLE. A write with IRAM_valid and done in same cycle is captured, then exit.
//   HALT: terminal after done; FIFO still accepts pushes, nothing issued until reset.
//  cmd holds last issued code after cmd_valid drops. Never two cmd_valid pulses < 3 cycles apart.
//  Duplicate IRAM_A in a capture overwrites buffer but still counts and sums (no dedupe).
//  IRAM_valid outside CAPTURE is ignored. Reset mid-capture aborts; outputs return to reset values.
//  rd_addr readable any time; read during same-address capture returns the old value.
// STRUCTURE
//  Package lcd_ctrl_pkg: command codes WRITE=0 .. MIRROR_Y=11, CMD_LAST=11, FSM state encoding.
//  Sub-module cmd_fifo (synchronous, FIFO_DEPTH x 4, full/empty flags, same-cycle push/pop).
//  Frame buffer: 64 x PIX_W register array, one write port, one registered read port.
// TESTING
//  Push SHIFT_UP(1) with busy=0 -> cmd=1, cmd_valid high exactly 1 cycle, 2 cycles after push.
//  Push 3 cmds while busy=1 -> nothing issued; drop busy -> issued in order, >=3 cycles apart.
//  Push 13 and 15 -> FIFO stays empty, drop_cnt=2, cmd_valid never asserted.
//  Push WRITE, drive 64 writes D=A -> checksum=2016, pix_cnt=64, frame_done pulse, rd_addr=10 -> 10.
//  Push WRITE, 20 writes then done=1 -> pix_cnt=20, frame_done, HALT; further pushes not issued.
//  Push 17 cmds with busy=1 -> push_ready low after 16; reset mid-capture -> all outputs at reset values.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the LCD controller command host.
// Holds the controller command codes, the host FSM state encoding and a
// small helper that tells legal command codes from illegal ones.
package lcd_ctrl_pkg;

  typedef logic [3:0] cmd_t;

  // Controller command codes; anything above CMD_LAST is illegal.
  localparam cmd_t WRITE       = 4'd0;
  localparam cmd_t SHIFT_UP    = 4'd1;
  localparam cmd_t SHIFT_DOWN  = 4'd2;
  localparam cmd_t SHIFT_LEFT  = 4'd3;
  localparam cmd_t SHIFT_RIGHT = 4'd4;
  localparam cmd_t MAX_OP      = 4'd5;
  localparam cmd_t MIN_OP      = 4'd6;
  localparam cmd_t AVERAGE     = 4'd7;
  localparam cmd_t ROTATE_CCW  = 4'd8;
  localparam cmd_t ROTATE_CW   = 4'd9;
  localparam cmd_t MIRROR_X    = 4'd10;
  localparam cmd_t MIRROR_Y    = 4'd11;
  localparam cmd_t CMD_LAST    = 4'd11;

  // Number of pixels in one frame write-back.
  localparam int FRAME_PIX = 64;

  // Host FSM state encoding.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_GUARD   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  localparam logic [2:0] ST_HALT    = 3'd5;

  function automatic logic is_legal_cmd(input cmd_t code);
    return code <= CMD_LAST;
  endfunction

endpackage

// File: rtl/lcd_cmd_host_if.sv
// Command/write-back bus between the command host and the LCD controller.
//  busy        controller busy
//  cmd         command code to the controller
//  cmd_valid   one-cycle command strobe
//  IRAM_valid  controller pixel write strobe
//  IRAM_A      pixel write address
//  IRAM_D      pixel write data
//  done        controller frame write-back finished
// The host uses the master modport, the controller (or a model of it) the slave.
interface lcd_cmd_host_if #(parameter int PIX_W = 8);
  import lcd_ctrl_pkg::*;

  logic             busy;
  cmd_t             cmd;
  logic             cmd_valid;
  logic             IRAM_valid;
  logic [5:0]       IRAM_A;
  logic [PIX_W-1:0] IRAM_D;
  logic             done;

  modport master (
    input  busy, IRAM_valid, IRAM_A, IRAM_D, done,
    output cmd, cmd_valid
  );

  modport slave (
    output busy, IRAM_valid, IRAM_A, IRAM_D, done,
    input  cmd, cmd_valid
  );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO, DEPTH x WIDTH, with full/empty flags.
//  clk, reset   clock, asynchronous active-high reset (empties the FIFO)
//  wr_en        write request (honoured when not full, or full with a pop)
//  wr_data      data written
//  rd_en        pop request (honoured when not empty)
//  rd_data      head of the FIFO (show-ahead, combinational)
//  full, empty  occupancy flags
module cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; a push and pop in the same cycle both take effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/lcd_cmd_host.sv
// Initiator side of the LCD controller command interface.
// Buffers pushed commands, issues them one at a time while honouring busy,
// and on a WRITE captures the 64-pixel write-back into a local frame buffer
// with a running checksum.
//  clk, reset   clock, asynchronous active-high reset
//  push_*       command push port (push_ready = FIFO not full)
//  bus          controller bus (master side)
//  rd_addr      frame buffer read address
//  rd_data      frame buffer data, registered, 1-cycle latency
//  frame_done   one-cycle pulse when a capture completes
//  checksum     sum of pixels captured in the current/last frame
//  pix_cnt      pixels captured in the current/last frame
//  drop_cnt     illegal codes discarded, saturating
module lcd_cmd_host
  import lcd_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  cmd_t              push_cmd,
  output logic              push_ready,
  lcd_cmd_host_if.master    bus,
  input  logic [5:0]        rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              frame_done,
  output logic [13:0]       checksum,
  output logic [6:0]        pix_cnt,
  output logic [7:0]        drop_cnt
);

  logic [2:0]       state;
  cmd_t             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_acc;
  logic             push_legal;
  logic             pop;
  logic             cap_wr;
  logic             cap_exit;
  logic [PIX_W-1:0] frame_mem [FRAME_PIX];

  assign push_ready = !fifo_full;
  assign push_acc   = push_valid && push_ready;
  assign push_legal = push_acc && is_legal_cmd(push_cmd);
  assign pop        = (state == ST_IDLE) && !fifo_empty && !bus.busy;
  assign cap_wr     = (state == ST_CAPTURE) && bus.IRAM_valid;
  // The write that brings the count to 64 ends the frame in the same cycle.
  assign cap_exit   = (state == ST_CAPTURE) &&
                      (bus.done || (cap_wr && pix_cnt == 7'(FRAME_PIX - 1)));

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_legal),
    .wr_data (push_cmd),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Issue sequencing and frame capture. cmd_valid is raised on the way into
  // ISSUE so it is high for exactly the ISSUE cycle; GUARD and WAIT keep
  // consecutive strobes well apart even if busy rises late.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      bus.cmd       <= WRITE;
      bus.cmd_valid <= 1'b0;
      frame_done    <= 1'b0;
      checksum      <= '0;
      pix_cnt       <= '0;
    end else begin
      bus.cmd_valid <= 1'b0;
      frame_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            bus.cmd       <= fifo_head;
            bus.cmd_valid <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_GUARD;
        ST_GUARD: state <= ST_WAIT;
        ST_WAIT: begin
          if (bus.cmd == WRITE) begin
            checksum <= '0;
            pix_cnt  <= '0;
            state    <= ST_CAPTURE;
          end else if (!bus.busy) begin
            state <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          if (cap_wr) begin
            checksum <= checksum + 14'(bus.IRAM_D);
            pix_cnt  <= pix_cnt + 7'd1;
          end
          if (cap_exit) begin
            frame_done <= 1'b1;
            state      <= bus.done ? ST_HALT : ST_IDLE;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Illegal codes are counted only when the push is actually accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (push_acc && !is_legal_cmd(push_cmd) && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Frame buffer write port; duplicate addresses simply overwrite.
  always_ff @(posedge clk) begin
    if (cap_wr) frame_mem[bus.IRAM_A] <= bus.IRAM_D;
  end

  // Registered read port; a read racing a write to the same address sees the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= frame_mem[rd_addr];
  end

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Self-checking bench for lcd_cmd_host with a behavioural model of the
// command queue, drop counter and frame buffer.
module tb_lcd_cmd_host;
  import lcd_ctrl_pkg::*;

  localparam int PIX_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             push_valid;
  logic [3:0]       push_cmd;
  logic             push_ready;
  logic [5:0]       rd_addr;
  logic [PIX_W-1:0] rd_data;
  logic             frame_done;
  logic [13:0]      checksum;
  logic [6:0]       pix_cnt;
  logic [7:0]       drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drop_exp = 0;

  logic [PIX_W-1:0] mem_m [64];
  logic [3:0]       iss_q [$];
  int               iss_cyc [$];

  lcd_cmd_host_if #(.PIX_W(PIX_W)) bus();

  lcd_cmd_host #(.FIFO_DEPTH(16), .PIX_W(PIX_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_cmd   (push_cmd),
    .push_ready (push_ready),
    .bus        (bus),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .checksum   (checksum),
    .pix_cnt    (pix_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every observed command strobe with the cycle it was seen in.
  always @(posedge clk) begin
    #2;
    if (bus.cmd_valid === 1'b1) begin
      iss_q.push_back(bus.cmd);
      iss_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic do_push(input logic [3:0] code, output int drive_cyc, output logic rdy);
    @(negedge clk);
    push_valid = 1'b1;
    push_cmd   = code;
    drive_cyc  = cyc;
    rdy        = push_ready;
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  task automatic wait_issues(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (iss_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive_pix(input logic v, input logic [5:0] a, input logic [PIX_W-1:0] d, input logic dn);
    bus.IRAM_valid = v;
    bus.IRAM_A     = a;
    bus.IRAM_D     = d;
    bus.done       = dn;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    push_valid = 1'b0; push_cmd = '0; rd_addr = '0;
    bus.busy = 1'b0;
    drive_pix(1'b0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd, bus.cmd_valid, push_ready, rd_data, frame_done, checksum, pix_cnt, drop_cnt} !==
        {4'd0, 1'b0, 1'b1, 8'd0, 1'b0, 14'd0, 7'd0, 8'd0}) begin
      errors++;
      $display("[TB] FAIL reset_values: got cmd=%0d vld=%0d rdy=%0d rd=%0d fd=%0d sum=%0d cnt=%0d drop=%0d expected 0 0 1 0 0 0 0 0",
               bus.cmd, bus.cmd_valid, push_ready, rd_data, frame_done, checksum, pix_cnt, drop_cnt);
    end
    reset = 1'b0;
    drop_exp = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_issue();
    int c0, n0;
    logic rdy;
    bit ok;
    n0 = iss_q.size();
    bus.busy = 1'b0;
    do_push(SHIFT_UP, c0, rdy);
    wait_issues(n0 + 1, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL single_issue_timeout: got %0d issues expected %0d", iss_q.size() - n0, 1);
    end else begin
      checks++;
      if (iss_q[n0] !== SHIFT_UP) begin
        errors++;
        $display("[TB] FAIL single_issue_code: got %0d expected %0d", iss_q[n0], SHIFT_UP);
      end
      checks++;
      if (iss_cyc[n0] - c0 != 2) begin
        errors++;
        $display("[TB] FAIL single_issue_latency: got %0d expected %0d", iss_cyc[n0] - c0, 2);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.cmd_valid !== 1'b0 || bus.cmd !== SHIFT_UP) begin
      errors++;
      $display("[TB] FAIL cmd_hold: got vld=%0d cmd=%0d expected vld=0 cmd=%0d", bus.cmd_valid, bus.cmd, SHIFT_UP);
    end
    checks++;
    if (iss_q.size() != n0 + 1) begin
      errors++;
      $display("[TB] FAIL single_issue_count: got %0d expected %0d", iss_q.size() - n0, 1);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_busy_hold();
    logic [3:0] exp_q [$];
    int c0, n0;
    logic rdy;
    bit ok;
    logic [3:0] code;
    n0 = iss_q.size();
    @(negedge clk);
    bus.busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      code = 4'($urandom_range(1, 11));
      exp_q.push_back(code);
      do_push(code, c0, rdy);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (iss_q.size() != n0) begin
      errors++;
      $display("[TB] FAIL busy_hold_no_issue: got %0d issues expected %0d", iss_q.size() - n0, 0);
    end
    bus.busy = 1'b0;
    wait_issues(n0 + 3, 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL busy_release_timeout: got %0d issues expected %0d", iss_q.size() - n0, 3);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (iss_q[n0 + k] !== exp_q[k]) begin
          errors++;
          $display("[TB] FAIL busy_order[%0d]: got %0d expected %0d", k, iss_q[n0 + k], exp_q[k]);
        end
        if (k > 0) begin
          checks++;
          if (iss_cyc[n0 + k] - iss_cyc[n0 + k - 1] < 3) begin
            errors++;
            $display("[TB] FAIL busy_spacing[%0d]: got %0d cycles expected >= 3", k, iss_cyc[n0 + k] - iss_cyc[n0 + k - 1]);
          end
        end
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random_cmds();
    logic [3:0] exp_q [$];
    int c0, n0;
    logic rdy;
    bit ok;
    logic [3:0] code;
    n0 = iss_q.size();
    for (int k = 0; k < 14; k++) begin
      code = 4'($urandom_range(1, 15));
      bus.busy = 1'($urandom_range(0, 1));
      if (code <= CMD_LAST) exp_q.push_back(code);
      else drop_exp = sat_inc(drop_exp);
      do_push(code, c0, rdy);
      checks++;
      if (rdy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL random_push_ready[%0d]: got %0d expected %0d", k, rdy, 1);
      end
    end
    bus.busy = 1'b0;
    wait_issues(n0 + exp_q.size(), 120, ok);
    repeat (6) @(negedge clk);
    checks++;
    if (iss_q.size() != n0 + exp_q.size()) begin
      errors++;
      $display("[TB] FAIL random_issue_count: got %0d expected %0d", iss_q.size() - n0, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (iss_q[n0 + k] !== exp_q[k]) begin
          errors++;
          $display("[TB] FAIL random_order[%0d]: got %0d expected %0d", k, iss_q[n0 + k], exp_q[k]);
        end
        if (k > 0 && iss_cyc[n0 + k] - iss_cyc[n0 + k - 1] < 3) begin
          errors++;
          $display("[TB] FAIL random_spacing[%0d]: got %0d cycles expected >= 3", k, iss_cyc[n0 + k] - iss_cyc[n0 + k - 1]);
        end
      end
    end
    checks++;
    if (drop_cnt !== 8'(drop_exp)) begin
      errors++;
      $display("[TB] FAIL random_drop_cnt: got %0d expected %0d", drop_cnt, drop_exp);
    end
  endtask

  task automatic test_illegal_drop();
    int c0, n0, base;
    logic rdy;
    n0 = iss_q.size();
    base = drop_exp;
    do_push(4'd13, c0, rdy);
    drop_exp = sat_inc(drop_exp);
    do_push(4'd15, c0, rdy);
    drop_exp = sat_inc(drop_exp);
    repeat (6) @(negedge clk);
    checks++;
    if (drop_cnt !== 8'(base + 2)) begin
      errors++;
      $display("[TB] FAIL drop_two: got %0d expected %0d", drop_cnt, base + 2);
    end
    for (int k = 0; k < 260; k++) begin
      do_push(4'($urandom_range(12, 15)), c0, rdy);
      drop_exp = sat_inc(drop_exp);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (drop_cnt !== 8'(drop_exp)) begin
      errors++;
      $display("[TB] FAIL drop_saturate: got %0d expected %0d", drop_cnt, drop_exp);
    end
    checks++;
    if (iss_q.size() != n0 || push_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drop_no_issue: got issues=%0d rdy=%0d expected issues=0 rdy=1", iss_q.size() - n0, push_ready);
    end
  endtask

  task automatic test_write_ramp();
    int c0, n0;
    logic rdy;
    bit ok;
    n0 = iss_q.size();
    bus.busy = 1'b0;
    do_push(WRITE, c0, rdy);
    wait_issues(n0 + 1, 20, ok);
    checks++;
    if (!ok || iss_q[n0] !== WRITE) begin
      errors++;
      $display("[TB] FAIL ramp_issue: got ok=%0d expected WRITE issued", ok);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      drive_pix(1'b1, 6'(i), 8'(i), 1'b0);
      mem_m[i] = 8'(i);
      @(negedge clk);
    end
    drive_pix(1'b0, '0, '0, 1'b0);
    checks++;
    if (frame_done !== 1'b1 || checksum !== 14'd2016 || pix_cnt !== 7'd64) begin
      errors++;
      $display("[TB] FAIL ramp_frame: got fd=%0d sum=%0d cnt=%0d expected 1 2016 64", frame_done, checksum, pix_cnt);
    end
    rd_addr = 6'd10;
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || rd_data !== 8'd10) begin
      errors++;
      $display("[TB] FAIL ramp_readback: got fd=%0d rd=%0d expected fd=0 rd=10", frame_done, rd_data);
    end
    drive_pix(1'b1, 6'd10, 8'hA5, 1'b0);
    @(negedge clk);
    drive_pix(1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (rd_data !== 8'd10 || checksum !== 14'd2016 || pix_cnt !== 7'd64) begin
      errors++;
      $display("[TB] FAIL idle_write_ignored: got rd=%0d sum=%0d cnt=%0d expected 10 2016 64", rd_data, checksum, pix_cnt);
    end
  endtask

  task automatic test_write_random();
    int c0, n0, cnt, sum;
    logic rdy;
    bit ok;
    logic v;
    logic [5:0] a;
    logic [PIX_W-1:0] d, exp_rd;
    n0 = iss_q.size();
    do_push(WRITE, c0, rdy);
    wait_issues(n0 + 1, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL rand_issue_timeout: got %0d issues expected %0d", iss_q.size() - n0, 1);
    end
    repeat (3) @(negedge clk);
    cnt = 0; sum = 0; exp_rd = '0;
    for (int i = 0; i < 400 && cnt < 64; i++) begin
      if (i > 0) begin
        checks++;
        if (rd_data !== exp_rd) begin
          errors++;
          $display("[TB] FAIL rand_read_old[%0d]: got %0d expected %0d", i, rd_data, exp_rd);
        end
      end
      v = ($urandom_range(0, 3) != 0);
      a = 6'($urandom_range(0, 63));
      d = 8'($urandom);
      exp_rd = mem_m[a];
      rd_addr = a;
      drive_pix(v, a, d, 1'b0);
      if (v) begin
        mem_m[a] = d;
        sum += d;
        cnt++;
      end
      @(negedge clk);
    end
    drive_pix(1'b0, '0, '0, 1'b0);
    checks++;
    if (frame_done !== 1'b1 || checksum !== 14'(sum) || pix_cnt !== 7'd64) begin
      errors++;
      $display("[TB] FAIL rand_frame: got fd=%0d sum=%0d cnt=%0d expected 1 %0d 64", frame_done, checksum, pix_cnt, sum);
    end
    for (int k = 0; k < 4; k++) begin
      a = 6'($urandom_range(0, 63));
      rd_addr = a;
      @(negedge clk);
      checks++;
      if (rd_data !== mem_m[a]) begin
        errors++;
        $display("[TB] FAIL rand_readback[%0d]: got %0d expected %0d", a, rd_data, mem_m[a]);
      end
    end
  endtask

  task automatic test_early_done();
    int c0, n0, sum;
    logic rdy;
    bit ok;
    logic [5:0] a;
    logic [PIX_W-1:0] d;
    n0 = iss_q.size();
    do_push(WRITE, c0, rdy);
    wait_issues(n0 + 1, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL early_issue_timeout: got %0d issues expected %0d", iss_q.size() - n0, 1);
    end
    repeat (3) @(negedge clk);
    sum = 0;
    for (int i = 0; i < 20; i++) begin
      a = 6'($urandom_range(0, 63));
      d = 8'($urandom);
      drive_pix(1'b1, a, d, i == 19);
      mem_m[a] = d;
      sum += d;
      @(negedge clk);
    end
    drive_pix(1'b0, '0, '0, 1'b0);
    checks++;
    if (frame_done !== 1'b1 || checksum !== 14'(sum) || pix_cnt !== 7'd20) begin
      errors++;
      $display("[TB] FAIL early_done_frame: got fd=%0d sum=%0d cnt=%0d expected 1 %0d 20", frame_done, checksum, pix_cnt, sum);
    end
    rd_addr = a;
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || rd_data !== mem_m[a]) begin
      errors++;
      $display("[TB] FAIL early_last_pixel: got fd=%0d rd=%0d expected fd=0 rd=%0d", frame_done, rd_data, mem_m[a]);
    end
    n0 = iss_q.size();
    do_push(SHIFT_DOWN, c0, rdy);
    drive_pix(1'b1, 6'd0, 8'hFF, 1'b0);
    @(negedge clk);
    drive_pix(1'b0, '0, '0, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (iss_q.size() != n0 || pix_cnt !== 7'd20 || push_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL halt_hold: got issues=%0d cnt=%0d rdy=%0d expected 0 20 1", iss_q.size() - n0, pix_cnt, push_ready);
    end
  endtask

  task automatic test_fifo_full_reset();
    logic [3:0] exp_q [$];
    int c0, n0;
    logic rdy;
    bit ok;
    logic [3:0] code;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drop_exp = 0;
    bus.busy = 1'b1;
    @(negedge clk);
    n0 = iss_q.size();
    for (int k = 0; k < 16; k++) begin
      code = (k == 15) ? WRITE : 4'($urandom_range(1, 11));
      exp_q.push_back(code);
      do_push(code, c0, rdy);
      checks++;
      if (rdy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL full_fill_ready[%0d]: got %0d expected %0d", k, rdy, 1);
      end
    end
    do_push(MIRROR_X, c0, rdy);
    checks++;
    if (rdy !== 1'b0 || push_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_push_ready: got %0d/%0d expected 0", rdy, push_ready);
    end
    bus.busy = 1'b0;
    wait_issues(n0 + 16, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL full_drain_timeout: got %0d issues expected %0d", iss_q.size() - n0, 16);
    end else begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (iss_q[n0 + k] !== exp_q[k]) begin
          errors++;
          $display("[TB] FAIL full_order[%0d]: got %0d expected %0d", k, iss_q[n0 + k], exp_q[k]);
        end
      end
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      drive_pix(1'b1, 6'(i), 8'($urandom_range(1, 255)), 1'b0);
      @(negedge clk);
    end
    drive_pix(1'b0, '0, '0, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.cmd, bus.cmd_valid, push_ready, rd_data, frame_done, checksum, pix_cnt, drop_cnt} !==
        {4'd0, 1'b0, 1'b1, 8'd0, 1'b0, 14'd0, 7'd0, 8'd0}) begin
      errors++;
      $display("[TB] FAIL midcapture_reset: got cmd=%0d vld=%0d rdy=%0d rd=%0d fd=%0d sum=%0d cnt=%0d drop=%0d expected 0 0 1 0 0 0 0 0",
               bus.cmd, bus.cmd_valid, push_ready, rd_data, frame_done, checksum, pix_cnt, drop_cnt);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n0 = iss_q.size();
    repeat (12) @(negedge clk);
    checks++;
    if (iss_q.size() != n0 || pix_cnt !== 7'd0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got issues=%0d cnt=%0d expected 0 0", iss_q.size() - n0, pix_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_busy_hold();
    test_random_cmds();
    test_illegal_drop();
    test_write_ramp();
    test_write_random();
    test_early_done();
    test_fifo_full_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
